fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/rv_pkg.sv | 16 +
 rtl/fetch_predictor.sv | 28 ++
 rtl/fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_stage.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-stage constants: FSM state encodings, the bubble instruction
// word and the RV32I opcodes the next-PC predictor recognises.
package rv_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_MEM = 2'd1,
    HOLD     = 2'd2,
    DISCARD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RV_NOP_INST = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL     = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;

endpackage

// File: rtl/fetch_predictor.sv
// Static next-PC predictor: JAL is always taken, backward conditional branches
// are taken, everything else falls through to pc+4. Purely combinational.
module fetch_predictor
  import rv_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic        is_jal;
  logic        is_bwd_br;

  always_comb begin
    j_imm     = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    b_imm     = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    is_jal    = (inst_i[6:0] == OPC_JAL);
    is_bwd_br = (inst_i[6:0] == OPC_BRANCH) && inst_i[31];
    taken_o   = is_jal || is_bwd_br;
    if (is_jal)         target_o = pc_i + j_imm;
    else if (is_bwd_br) target_o = pc_i + b_imm;
    else                target_o = pc_i + 32'd4;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry stall buffer and
// flush handling. Define FETCH_PREDICT_EN to enable static next-PC prediction.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = RV_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_id_o,
  output logic [31:0] pc_id_o,
  output logic        valid_id_o,
  output logic        pred_taken_id_o,
  output logic        fetch_busy_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc_id_q, pc_id_d;
  logic         valid_q, valid_d;
  logic         pred_q, pred_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic         hold_pred_q, hold_pred_d;

  logic [31:0]  cur_addr;
  logic [31:0]  next_pc;
  logic         pred_taken;
  logic         word_ok;

  // pc_q is the next address to request; req_addr_q pins the address of an
  // in-flight request so a flush can retarget pc_q without moving imem_addr_o.
  assign cur_addr = (state_q == FETCH || state_q == HOLD) ? pc_q : req_addr_q;

`ifdef FETCH_PREDICT_EN
  fetch_predictor u_pred (
    .pc_i     (cur_addr),
    .inst_i   (imem_rdata_i),
    .taken_o  (pred_taken),
    .target_o (next_pc)
  );
`else
  always_comb begin
    pred_taken = 1'b0;
    next_pc    = cur_addr + 32'd4;
  end
`endif

  assign word_ok = imem_ready_i && !flush_i &&
                   (state_q == FETCH || state_q == WAIT_MEM);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    inst_d      = inst_q;
    pc_id_d     = pc_id_q;
    valid_d     = valid_q;
    pred_d      = pred_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    hold_pred_d = hold_pred_q;

    if (flush_i) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      pred_d  = 1'b0;
    end else if (!stall_i) begin
      if (word_ok) begin
        inst_d  = imem_rdata_i;
        pc_id_d = cur_addr;
        valid_d = 1'b1;
        pred_d  = pred_taken;
      end else if (state_q == HOLD) begin
        inst_d  = hold_inst_q;
        pc_id_d = hold_pc_q;
        valid_d = 1'b1;
        pred_d  = hold_pred_q;
      end else begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        pred_d  = 1'b0;
      end
    end

    if (word_ok && stall_i) begin
      hold_inst_d = imem_rdata_i;
      hold_pc_d   = cur_addr;
      hold_pred_d = pred_taken;
    end

    unique case (state_q)
      FETCH, WAIT_MEM: begin
        if (flush_i) begin
          pc_d       = redirect_pc_i;
          req_addr_d = cur_addr;
          state_d    = imem_ready_i ? FETCH : DISCARD;
        end else if (imem_ready_i) begin
          pc_d    = next_pc;
          state_d = stall_i ? HOLD : FETCH;
        end else if (state_q == FETCH) begin
          req_addr_d = pc_q;
          state_d    = WAIT_MEM;
        end
      end
      HOLD: begin
        if (flush_i) begin
          pc_d    = redirect_pc_i;
          state_d = FETCH;
        end else if (!stall_i) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (flush_i) pc_d = redirect_pc_i;
        if (imem_ready_i) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      inst_q      <= NOP_INST;
      pc_id_q     <= '0;
      valid_q     <= 1'b0;
      pred_q      <= 1'b0;
      hold_inst_q <= NOP_INST;
      hold_pc_q   <= '0;
      hold_pred_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      inst_q      <= inst_d;
      pc_id_q     <= pc_id_d;
      valid_q     <= valid_d;
      pred_q      <= pred_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      hold_pred_q <= hold_pred_d;
    end
  end

  assign imem_req_o      = !rst && (state_q != HOLD);
  assign imem_addr_o     = cur_addr;
  assign fetch_busy_o    = (state_q == WAIT_MEM) || (state_q == DISCARD);
  assign inst_id_o       = inst_q;
  assign pc_id_o         = pc_id_q;
  assign valid_id_o      = valid_q;
  assign pred_taken_id_o = pred_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: each row drives one cycle and
// checks the outputs visible in that cycle before the next rising edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;
`ifdef FETCH_PREDICT_EN
  localparam logic        P_TAKEN = 1'b1;
  localparam logic [31:0] P_NEXT  = 32'h0000_0038;
`else
  localparam logic        P_TAKEN = 1'b0;
  localparam logic [31:0] P_NEXT  = 32'h0000_0044;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, ready;
  logic [31:0] redir, rdata;
  logic        req, valid, pred, busy;
  logic [31:0] addr, inst, pc_id;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .redirect_pc_i(redir), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ready_i(ready), .imem_rdata_i(rdata), .inst_id_o(inst),
    .pc_id_o(pc_id), .valid_id_o(valid), .pred_taken_id_o(pred),
    .fetch_busy_o(busy)
  );

  typedef struct {
    logic        rst, stall, flush;
    logic [31:0] redir;
    logic        ready;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy, e_valid;
    logic [31:0] e_inst, e_pc;
    logic        e_pred;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  function automatic void add(input logic r, s, f, input logic [31:0] rd,
                              input logic rdy, input logic [31:0] dat,
                              input logic eq, input logic [31:0] ea,
                              input logic eb, ev, input logic [31:0] ei, ep,
                              input logic epr);
    vec_t v;
    v = '{r, s, f, rd, rdy, dat, eq, ea, eb, ev, ei, ep, epr};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, f, input logic [31:0] rd,
                       input logic rdy, input logic [31:0] dat);
    @(negedge clk);
    rst = r; stall = s; flush = f; redir = rd; ready = rdy; rdata = dat;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; ready = 1'b0;
    redir = '0; rdata = '0;
    repeat (2) @(posedge clk);

    //    rst stl fl redir  rdy rdata       | req addr  busy vld inst      pc_id   pred
    add(1, 0, 0, 0,      0, 0,          0, 32'h0,   0, 0, NOP,      32'h0,  0); // v0 reset
    add(0, 0, 0, 0,      1, w(0),       1, 32'h0,   0, 0, NOP,      32'h0,  0); // v1 first req
    add(0, 0, 0, 0,      1, w(4),       1, 32'h4,   0, 1, w(0),     32'h0,  0);
    add(0, 0, 0, 0,      0, 0,          1, 32'h8,   0, 1, w(4),     32'h4,  0); // miss at 0x8
    add(0, 0, 0, 0,      0, 0,          1, 32'h8,   1, 0, NOP,      32'h4,  0);
    add(0, 0, 0, 0,      0, 0,          1, 32'h8,   1, 0, NOP,      32'h4,  0);
    add(0, 0, 0, 0,      1, w(8),       1, 32'h8,   1, 0, NOP,      32'h4,  0);
    add(0, 0, 0, 0,      1, w(32'hC),   1, 32'hC,   0, 1, w(8),     32'h8,  0);
    add(0, 1, 0, 0,      1, w(32'h10),  1, 32'h10,  0, 1, w(32'hC), 32'hC,  0); // stall on 0x10
    add(0, 1, 0, 0,      0, 0,          0, 32'h14,  0, 1, w(32'hC), 32'hC,  0); // HOLD
    add(0, 0, 0, 0,      0, 0,          0, 32'h14,  0, 1, w(32'hC), 32'hC,  0); // release
    add(0, 0, 0, 0,      1, w(32'h14),  1, 32'h14,  0, 1, w(32'h10),32'h10, 0);
    add(0, 0, 0, 0,      1, w(32'h18),  1, 32'h18,  0, 1, w(32'h14),32'h14, 0);
    add(0, 0, 0, 0,      1, w(32'h1C),  1, 32'h1C,  0, 1, w(32'h18),32'h18, 0);
    add(0, 0, 0, 0,      0, 0,          1, 32'h20,  0, 1, w(32'h1C),32'h1C, 0);
    add(0, 0, 1, 32'h100,0, 0,          1, 32'h20,  1, 0, NOP,      32'h1C, 0); // flush in WAIT_MEM
    add(0, 0, 0, 0,      1, w(32'h20),  1, 32'h20,  1, 0, NOP,      32'h1C, 0); // stale word
    add(0, 0, 0, 0,      1, w(32'h100), 1, 32'h100, 0, 0, NOP,      32'h1C, 0);
    add(0, 1, 0, 0,      1, w(32'h104), 1, 32'h104, 0, 1, w(32'h100),32'h100,0);
    add(0, 1, 1, 32'h200,0, 0,          0, 32'h108, 0, 1, w(32'h100),32'h100,0); // stall+flush
    add(0, 1, 0, 0,      0, 0,          1, 32'h200, 0, 0, NOP,      32'h100,0);
    add(0, 0, 0, 0,      1, w(32'h200), 1, 32'h200, 1, 0, NOP,      32'h100,0);
    add(0, 0, 0, 0,      0, 0,          1, 32'h204, 0, 1, w(32'h200),32'h200,0);
    add(0, 0, 1, 32'h40, 1, w(32'h204), 1, 32'h204, 1, 0, NOP,      32'h200,0); // flush with ready
    add(0, 0, 0, 0,      1, BEQ_M8,     1, 32'h40,  0, 0, NOP,      32'h200,0);
    add(0, 0, 0, 0,      0, 0,          1, P_NEXT,  0, 1, BEQ_M8,   32'h40, P_TAKEN);
    add(1, 0, 0, 0,      1, w(P_NEXT),  0, P_NEXT,  1, 0, NOP,      32'h40, 0); // reset in WAIT_MEM
    add(0, 0, 0, 0,      1, w(0),       1, 32'h0,   0, 0, NOP,      32'h0,  0);
    add(0, 0, 0, 0,      0, 0,          1, 32'h4,   0, 1, w(0),     32'h0,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].redir,
            vecs[i].ready, vecs[i].rdata);
      chk($sformatf("v%0d.req", i),   {31'd0, req},   {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d.addr", i),  addr,           vecs[i].e_addr);
      chk($sformatf("v%0d.busy", i),  {31'd0, busy},  {31'd0, vecs[i].e_busy});
      chk($sformatf("v%0d.valid", i), {31'd0, valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d.inst", i),  inst,           vecs[i].e_inst);
      chk($sformatf("v%0d.pc_id", i), pc_id,          vecs[i].e_pc);
      chk($sformatf("v%0d.pred", i),  {31'd0, pred},  {31'd0, vecs[i].e_pred});
    end

    // Two flushes while the 0x4 request is outstanding: the later target wins.
    drive(0, 0, 1, 32'h300, 0, 0);
    chk("dbl.busy0", {31'd0, busy}, 32'd1);
    chk("dbl.addr0", addr, 32'h4);
    drive(0, 0, 1, 32'h400, 0, 0);
    chk("dbl.busy1", {31'd0, busy}, 32'd1);
    chk("dbl.addr1", addr, 32'h4);
    chk("dbl.req1",  {31'd0, req},  32'd1);
    drive(0, 0, 0, 0, 1, w(32'h4));
    chk("dbl.addr2", addr, 32'h4);
    drive(0, 0, 0, 0, 0, 0);
    chk("dbl.addr3",  addr, 32'h400);
    chk("dbl.busy3",  {31'd0, busy},  32'd0);
    chk("dbl.valid3", {31'd0, valid}, 32'd0);
    chk("dbl.inst3",  inst, NOP);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
